// File: rtl/vh_sig_pkg.sv
// Shared types and defaults for the signature-capture block and its MISR helpers.
// The MISR step folds one data word into the register: shift left, apply the
// polynomial when the bit shifted out was set, then XOR in the zero-extended word.
package vh_sig_pkg;

  typedef logic [1:0] state_t;

  localparam state_t StIdle = 2'd0;
  localparam state_t StRun  = 2'd1;
  localparam state_t StDone = 2'd2;

  localparam logic [31:0] DefaultPoly = 32'h04C1_1DB7;
  localparam logic [31:0] DefaultSeed = 32'h0000_0000;

  // 32-bit form of the MISR step for callers that do not instantiate vh_misr_next.
  function automatic logic [31:0] misr_next32(input logic [31:0] sig_in,
                                              input logic [31:0] data_in,
                                              input logic [31:0] poly);
    return {sig_in[30:0], 1'b0} ^ (sig_in[31] ? poly : 32'h0) ^ data_in;
  endfunction

endpackage

// File: rtl/vh_misr_next.sv
// Combinational single-step MISR update: one data word folded into the signature.
module vh_misr_next
  import vh_sig_pkg::*;
#(
  parameter int unsigned      SIG_W = 32,
  parameter int unsigned      WIDTH = 30,
  parameter logic [SIG_W-1:0] POLY  = DefaultPoly
) (
  input  logic [SIG_W-1:0] sig_in,
  input  logic [WIDTH-1:0] data_in,
  output logic [SIG_W-1:0] sig_out
);

  logic [SIG_W-1:0] data_ext;

  always_comb begin
    data_ext               = '0;
    data_ext[WIDTH-1:0]    = data_in;
    sig_out = {sig_in[SIG_W-2:0], 1'b0} ^ (sig_in[SIG_W-1] ? POLY : '0) ^ data_ext;
  end

endmodule

// File: rtl/vh_sig_capture.sv
// Response compactor: folds a programmed number of handshaken result words into a
// MISR and reports the final signature plus a compare against an expected value.
module vh_sig_capture
  import vh_sig_pkg::*;
#(
  parameter int unsigned      WIDTH = 30,
  parameter int unsigned      SIG_W = 32,
  parameter logic [SIG_W-1:0] POLY  = DefaultPoly,
  parameter logic [SIG_W-1:0] SEED  = DefaultSeed,
  parameter int unsigned      CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_vec,
  input  logic [SIG_W-1:0] exp_sig,
  input  logic             y_valid,
  input  logic [WIDTH-1:0] y,
  output logic             y_ready,
  output logic             busy,
  output logic [CNT_W-1:0] vec_cnt,
  output logic [SIG_W-1:0] sig,
  output logic             sig_valid,
  output logic             match
);

  state_t           state_q, state_d;
  logic [SIG_W-1:0] sig_q, sig_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] num_q, num_d;
  logic [SIG_W-1:0] exp_q, exp_d;

  logic [SIG_W-1:0] sig_nxt;
  logic [CNT_W-1:0] cnt_inc;
  logic             beat;

  vh_misr_next #(
    .SIG_W (SIG_W),
    .WIDTH (WIDTH),
    .POLY  (POLY)
  ) u_misr_next (
    .sig_in  (sig_q),
    .data_in (y),
    .sig_out (sig_nxt)
  );

  assign cnt_inc = cnt_q + 1'b1;
  assign beat    = y_valid & y_ready;

  always_comb begin
    state_d = state_q;
    sig_d   = sig_q;
    cnt_d   = cnt_q;
    num_d   = num_q;
    exp_d   = exp_q;
    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          sig_d   = SEED;
          cnt_d   = '0;
          num_d   = num_vec;
          exp_d   = exp_sig;
          state_d = (num_vec == '0) ? StDone : StRun;
        end
      end
      StRun: begin
        // Only a real beat touches sig, so an undriven y with y_valid low cannot leak in.
        if (beat) begin
          sig_d = sig_nxt;
          cnt_d = cnt_inc;
          if (cnt_inc == num_q) begin
            state_d = StDone;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      sig_q   <= SEED;
      cnt_q   <= '0;
      num_q   <= '0;
      exp_q   <= '0;
    end else begin
      state_q <= state_d;
      sig_q   <= sig_d;
      cnt_q   <= cnt_d;
      num_q   <= num_d;
      exp_q   <= exp_d;
    end
  end

  assign y_ready   = (state_q == StRun);
  assign busy      = (state_q == StRun);
  assign sig_valid = (state_q == StDone);
  assign match     = sig_valid && (sig_q == exp_q);
  assign vec_cnt   = cnt_q;
  assign sig       = sig_q;

endmodule

// File: tb/tb_vh_sig_capture.sv
// Bench for vh_sig_capture: two instances (zero seed and top-bit seed) share stimulus
// and are compared every cycle against a transaction-level model, plus literal pins.
module tb_vh_sig_capture;

  localparam logic [31:0] POLY  = 32'h04C1_1DB7;
  localparam logic [31:0] SEED0 = 32'h0000_0000;
  localparam logic [31:0] SEED1 = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] num_vec;
  logic [31:0] exp_sig;
  logic        y_valid;
  logic [29:0] y;

  logic        y_ready0, busy0, sig_valid0, match0;
  logic [15:0] vec_cnt0;
  logic [31:0] sig0;
  logic        y_ready1, busy1, sig_valid1, match1;
  logic [15:0] vec_cnt1;
  logic [31:0] sig1;

  int checks = 0;
  int errors = 0;

  // Model state: phase 0 idle, 1 collecting words, 2 signature final.
  int          m_phase = 0;
  int          m_cnt   = 0;
  int          m_num   = 0;
  logic [31:0] m_exp   = 32'h0;
  logic [31:0] m_sig0  = SEED0;
  logic [31:0] m_sig1  = SEED1;

  always #5 clk = ~clk;

  vh_sig_capture dut0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .num_vec   (num_vec),
    .exp_sig   (exp_sig),
    .y_valid   (y_valid),
    .y         (y),
    .y_ready   (y_ready0),
    .busy      (busy0),
    .vec_cnt   (vec_cnt0),
    .sig       (sig0),
    .sig_valid (sig_valid0),
    .match     (match0)
  );

  vh_sig_capture #(
    .SEED (SEED1)
  ) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .num_vec   (num_vec),
    .exp_sig   (exp_sig),
    .y_valid   (y_valid),
    .y         (y),
    .y_ready   (y_ready1),
    .busy      (busy1),
    .vec_cnt   (vec_cnt1),
    .sig       (sig1),
    .sig_valid (sig_valid1),
    .match     (match1)
  );

  function automatic logic [31:0] fold(input logic [31:0] s, input logic [29:0] w);
    logic [31:0] fb;
    fb = s[31] ? POLY : 32'h0;
    return (s << 1) ^ fb ^ {2'b00, w};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  // Model: advance on each clock edge from the inputs the bench applied.
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_phase = 0; m_cnt = 0; m_num = 0; m_exp = 32'h0; m_sig0 = SEED0; m_sig1 = SEED1;
      end else if (m_phase != 1) begin
        if (start) begin
          m_sig0  = SEED0;
          m_sig1  = SEED1;
          m_cnt   = 0;
          m_num   = int'(num_vec);
          m_exp   = exp_sig;
          m_phase = (num_vec == 16'd0) ? 2 : 1;
        end
      end else if (y_valid) begin
        m_sig0 = fold(m_sig0, y);
        m_sig1 = fold(m_sig1, y);
        m_cnt++;
        if (m_cnt == m_num) m_phase = 2;
      end
    end
  end

  // Compare every cycle on the falling edge, away from state updates.
  initial begin
    forever begin
      @(negedge clk);
      chk("d0_y_ready",   {31'd0, y_ready0},   {31'd0, m_phase == 1});
      chk("d0_busy",      {31'd0, busy0},      {31'd0, m_phase == 1});
      chk("d0_sig_valid", {31'd0, sig_valid0}, {31'd0, m_phase == 2});
      chk("d0_match",     {31'd0, match0},     {31'd0, (m_phase == 2) && (m_sig0 == m_exp)});
      chk("d0_vec_cnt",   {16'd0, vec_cnt0},   32'(m_cnt));
      chk("d0_sig",       sig0,                m_sig0);
      chk("d1_y_ready",   {31'd0, y_ready1},   {31'd0, m_phase == 1});
      chk("d1_sig_valid", {31'd0, sig_valid1}, {31'd0, m_phase == 2});
      chk("d1_match",     {31'd0, match1},     {31'd0, (m_phase == 2) && (m_sig1 == m_exp)});
      chk("d1_vec_cnt",   {16'd0, vec_cnt1},   32'(m_cnt));
      chk("d1_sig",       sig1,                m_sig1);
    end
  end

  // Apply one cycle of inputs; returns 1 time unit after the following falling edge.
  task automatic step(input logic st, input logic [15:0] nv, input logic [31:0] es,
                      input logic v, input logic [29:0] yy);
    start = st; num_vec = nv; exp_sig = es; y_valid = v; y = yy;
    @(negedge clk);
    #1;
  endtask

  initial begin
    logic [29:0] words [4];
    logic        bp [6];
    bit          seen;
    words = '{30'd1, 30'd2, 30'd3, 30'd4};
    bp    = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    // Reset with a word offered: nothing may be accepted.
    rst_n = 1'b0;
    step(1'b0, 16'd0, 32'h0, 1'b1, 30'h5);
    step(1'b0, 16'd0, 32'h0, 1'b1, 30'h5);
    chk("rst_y_ready",   {31'd0, y_ready0},   32'd0);
    chk("rst_sig",       sig0,                32'h0);
    chk("rst_sig_valid", {31'd0, sig_valid0}, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) step(1'b0, 16'd0, 32'h0, 1'b0, 30'h0);

    // Basic run: words 1 then 0 give signature 2.
    step(1'b1, 16'd2, 32'd2, 1'b0, 30'h0);
    step(1'b0, 16'd0, 32'h0, 1'b1, 30'd1);
    chk("basic_sig_b1", sig0, 32'd1);
    step(1'b0, 16'd0, 32'h0, 1'b1, 30'd0);
    chk("basic_sig_b2",   sig0,                32'd2);
    chk("basic_valid",    {31'd0, sig_valid0}, 32'd1);
    chk("basic_match",    {31'd0, match0},     32'd1);
    chk("basic_vec_cnt",  {16'd0, vec_cnt0},   32'd2);
    chk("basic_ready_lo", {31'd0, y_ready0},   32'd0);
    step(1'b0, 16'd0, 32'h0, 1'b1, 30'd7);
    step(1'b0, 16'd0, 32'h0, 1'b1, 30'd7);

    // Gaps in y_valid, with y undriven during the gaps.
    step(1'b1, 16'd3, 32'h0, 1'b0, 'x);
    for (int i = 0; i < 6; i++) step(1'b0, 16'd0, 32'h0, bp[i], bp[i] ? 30'h3FFF_FFFF : 'x);
    chk("bp_sig",     sig0,              32'hBFFF_FFFD);
    chk("bp_vec_cnt", {16'd0, vec_cnt0}, 32'd3);
    step(1'b0, 16'd0, 32'h0, 1'b0, 30'h0);

    // Top seed bit feeds the polynomial back; expected 0 mismatches on that instance.
    step(1'b1, 16'd1, 32'h0, 1'b0, 30'h0);
    step(1'b0, 16'd0, 32'h0, 1'b1, 30'h0);
    chk("fb_sig",    sig1,                32'h04C1_1DB7);
    chk("fb_valid",  {31'd0, sig_valid1}, 32'd1);
    chk("fb_match",  {31'd0, match1},     32'd0);
    chk("fb_d0_match", {31'd0, match0},   32'd1);

    // Zero-length run, then restart.
    step(1'b1, 16'd0, 32'h0, 1'b1, 30'h9);
    chk("zero_valid", {31'd0, sig_valid0}, 32'd1);
    chk("zero_sig1",  sig1,                SEED1);
    step(1'b0, 16'd0, 32'h0, 1'b0, 30'h0);
    step(1'b1, 16'd1, 32'd5, 1'b0, 30'h0);
    chk("restart_valid_drop", {31'd0, sig_valid0}, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step(1'b0, 16'd0, 32'h0, 1'b1, 30'd5);
      seen = sig_valid0;
    end
    chk("restart_done",  {31'd0, seen},  32'd1);
    chk("restart_sig",   sig0,           32'd5);
    chk("restart_match", {31'd0, match0}, 32'd1);

    // Reset after one of four beats, then a clean run of the same four words.
    step(1'b1, 16'd4, 32'd2, 1'b0, 30'h0);
    step(1'b0, 16'd0, 32'h0, 1'b1, words[0]);
    rst_n = 1'b0;
    #1;
    chk("midrst_sig0",    sig0,              SEED0);
    chk("midrst_sig1",    sig1,              SEED1);
    chk("midrst_vec_cnt", {16'd0, vec_cnt0}, 32'd0);
    chk("midrst_ready",   {31'd0, y_ready0}, 32'd0);
    step(1'b0, 16'd0, 32'h0, 1'b1, words[1]);
    rst_n = 1'b1;
    step(1'b1, 16'd4, 32'd2, 1'b0, 30'h0);
    for (int i = 0; i < 4; i++) step(1'b0, 16'd0, 32'h0, 1'b1, words[i]);
    chk("rerun_sig",   sig0,                32'd2);
    chk("rerun_match", {31'd0, match0},     32'd1);
    chk("rerun_valid", {31'd0, sig_valid0}, 32'd1);
    step(1'b0, 16'd0, 32'h0, 1'b0, 30'h0);
    step(1'b0, 16'd0, 32'h0, 1'b0, 30'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
